// File: rtl/ap_line_if.sv
// Sequencer-facing bundle of the ap_line tape: step requests in, pointer/cell/flags out.
// The master is the instruction sequencer, the slave is the tape.
interface ap_line_if #(
  parameter int ADDR_DIGITS = 5,
  parameter int DATA_DIGITS = 3
);
  logic                     ApRequest;
  logic                     DataRequest;
  logic                     Dec;
  logic                     Ready;
  logic [4*ADDR_DIGITS-1:0] Address;
  logic [4*DATA_DIGITS-1:0] Data;
  logic                     ApZero;
  logic                     DataZero;

  modport master (
    output ApRequest, DataRequest, Dec,
    input  Ready, Address, Data, ApZero, DataZero
  );

  modport slave (
    input  ApRequest, DataRequest, Dec,
    output Ready, Address, Data, ApZero, DataZero
  );
endinterface

// File: rtl/ap_line.sv
// DekatronPC data tape: BCD address pointer with a mirrored binary index, and
// BCD +/-1 of the addressed cell. Memory is zeroed by a CLEAR sweep after reset.
module ap_line #(
  parameter int ADDR_DIGITS = 5,
  parameter int DATA_DIGITS = 3,
  parameter int MEM_DEPTH   = 256
) (
  input  logic     Clk,
  input  logic     Rst_n,
  ap_line_if.slave bus
);
  localparam int AW = 4 * ADDR_DIGITS;
  localparam int DW = 4 * DATA_DIGITS;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {CLEAR, IDLE, AP_STEP, AP_LOAD, DATA_WR} state_t;

  function automatic logic [AW-1:0] addr_to_bcd(input int v);
    logic [AW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int i = 0; i < ADDR_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  localparam logic [AW-1:0] ADDR_LAST = addr_to_bcd(MEM_DEPTH - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(MEM_DEPTH - 1);

  // Ripple a +/-1 through the BCD digits; overflow out of the top digit wraps.
  function automatic logic [AW-1:0] addr_step(input logic [AW-1:0] a, input logic dec);
    logic [AW-1:0] r;
    logic          c;
    r = a;
    c = 1'b1;
    for (int i = 0; i < ADDR_DIGITS; i++) begin
      if (c) begin
        if (!dec) begin
          if (a[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin r[4*i +: 4] = a[4*i +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (a[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin r[4*i +: 4] = a[4*i +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] data_step(input logic [DW-1:0] d, input logic dec);
    logic [DW-1:0] r;
    logic          c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < DATA_DIGITS; i++) begin
      if (c) begin
        if (!dec) begin
          if (d[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin r[4*i +: 4] = d[4*i +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (d[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin r[4*i +: 4] = d[4*i +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] clr_q, clr_d;
  logic          dec_q, dec_d;
  logic          we;
  logic [IW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] mem [MEM_DEPTH];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    clr_d   = clr_q;
    dec_d   = dec_q;
    we      = 1'b0;
    waddr   = idx_q;
    wdata   = '0;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        if (clr_q == IDX_LAST) begin
          clr_d   = '0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + IW'(1);
        end
      end
      IDLE: begin
        // Pointer request has priority; a simultaneous cell request is dropped.
        if (bus.ApRequest) begin
          dec_d   = bus.Dec;
          state_d = AP_STEP;
        end else if (bus.DataRequest) begin
          dec_d   = bus.Dec;
          state_d = DATA_WR;
        end
      end
      AP_STEP: begin
        if (!dec_q) begin
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            addr_d = '0;
          end else begin
            idx_d  = idx_q + IW'(1);
            addr_d = addr_step(addr_q, 1'b0);
          end
        end else begin
          if (idx_q == '0) begin
            idx_d  = IDX_LAST;
            addr_d = ADDR_LAST;
          end else begin
            idx_d  = idx_q - IW'(1);
            addr_d = addr_step(addr_q, 1'b1);
          end
        end
        state_d = AP_LOAD;
      end
      AP_LOAD: begin
        data_d  = rd_q;
        state_d = IDLE;
      end
      DATA_WR: begin
        data_d  = data_step(data_q, dec_q);
        we      = 1'b1;
        wdata   = data_d;
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= CLEAR;
      addr_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      clr_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
      dec_q   <= dec_d;
    end
  end

  // Read port addressed by the next pointer so the new cell is ready in AP_LOAD.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[idx_d];
  end

  assign bus.Ready    = (state_q == IDLE);
  assign bus.Address  = addr_q;
  assign bus.Data     = data_q;
  assign bus.ApZero   = (addr_q == '0);
  assign bus.DataZero = (data_q == '0);
endmodule

// File: tb/tb_ap_line.sv
// Directed + randomized bench for ap_line against an integer pointer/cell model.
module tb_ap_line;
  logic Clk = 1'b0;
  logic Rst_n = 1'b1;
  always #5 Clk = ~Clk;

  ap_line_if #(.ADDR_DIGITS(5), .DATA_DIGITS(3)) bus ();

  ap_line #(.ADDR_DIGITS(5), .DATA_DIGITS(3), .MEM_DEPTH(256)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  int ptr    = 0;
  int cells [256];

  always @(posedge bus.Ready) rises++;

  function automatic logic [63:0] bcd(input int v);
    logic [63:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_addr"},  64'(bus.Address),  bcd(ptr));
    check({tag, "_data"},  64'(bus.Data),     bcd(cells[ptr]));
    check({tag, "_apz"},   64'(bus.ApZero),   64'(ptr == 0));
    check({tag, "_dataz"}, 64'(bus.DataZero), 64'(cells[ptr] == 0));
    check({tag, "_ready"}, 64'(bus.Ready),    64'd1);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (bus.Ready !== 1'b1 && n < 20);
  endtask

  task automatic do_reset();
    int n;
    Rst_n = 1'b0;
    #2;
    check("rst_ready", 64'(bus.Ready),    64'd0);
    check("rst_addr",  64'(bus.Address),  64'd0);
    check("rst_data",  64'(bus.Data),     64'd0);
    check("rst_apz",   64'(bus.ApZero),   64'd1);
    check("rst_dataz", 64'(bus.DataZero), 64'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (bus.Ready !== 1'b1 && n < 400);
    check("clear_len", 64'(n), 64'd256);
    ptr = 0;
    foreach (cells[i]) cells[i] = 0;
    check_state("post_clear");
  endtask

  task automatic do_req(input bit ap, input bit dt, input bit dec);
    int n;
    @(negedge Clk);
    bus.ApRequest   = ap;
    bus.DataRequest = dt;
    bus.Dec         = dec;
    @(posedge Clk);
    #1;
    bus.ApRequest   = 1'b0;
    bus.DataRequest = 1'b0;
    check("accept_busy", 64'(bus.Ready), 64'd0);
    wait_ready(n);
    check(ap ? "ap_latency" : "data_latency", 64'(n), ap ? 64'd2 : 64'd1);
    if (ap) ptr = dec ? (ptr + 255) % 256 : (ptr + 1) % 256;
    else    cells[ptr] = dec ? (cells[ptr] + 999) % 1000 : (cells[ptr] + 1) % 1000;
    check_state(ap ? "ap" : "data");
  endtask

  initial begin
    int n;
    int r0;
    int acc;
    bus.ApRequest   = 1'b0;
    bus.DataRequest = 1'b0;
    bus.Dec         = 1'b0;
    #3;
    do_reset();

    repeat (15) do_req(1'b0, 1'b1, 1'b0);
    check("plan_015", 64'(bus.Data), 64'h015);
    repeat (10) do_req(1'b1, 1'b0, 1'b0);
    check("plan_addr10", 64'(bus.Address), 64'h00010);
    repeat (17) do_req(1'b0, 1'b1, 1'b0);
    check("plan_017", 64'(bus.Data), 64'h017);
    repeat (10) do_req(1'b1, 1'b0, 1'b1);
    check("plan_back_015", 64'(bus.Data), 64'h015);
    repeat (15) do_req(1'b0, 1'b1, 1'b1);
    check("plan_zero", 64'(bus.DataZero), 64'd1);

    do_req(1'b0, 1'b1, 1'b1);
    check("wrap_999", 64'(bus.Data), 64'h999);
    do_req(1'b1, 1'b0, 1'b1);
    check("wrap_255", 64'(bus.Address), 64'h00255);
    do_req(1'b1, 1'b0, 1'b0);
    check("wrap_0", 64'(bus.Address), 64'h00000);

    // Both requests together: pointer moves, cell untouched.
    do_req(1'b1, 1'b1, 1'b0);
    check("both_addr", 64'(bus.Address), 64'h00001);

    // A cell request raised while the pointer move is in flight is dropped.
    r0 = rises;
    @(negedge Clk);
    bus.ApRequest = 1'b1;
    bus.Dec       = 1'b1;
    @(posedge Clk);
    #1;
    bus.ApRequest   = 1'b0;
    bus.DataRequest = 1'b1;
    wait_ready(n);
    bus.DataRequest = 1'b0;
    check("busy_latency", 64'(n), 64'd2);
    ptr = 0;
    check_state("busy_ignored");
    @(posedge Clk);
    #1;
    check_state("busy_after");
    check("busy_rises", 64'(rises - r0), 64'd1);

    r0  = rises;
    acc = 0;
    for (int k = 0; k < 200; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_req(kind != 1, kind != 0, 1'($urandom_range(0, 1)));
      acc++;
    end
    check("rand_rises", 64'(rises - r0), 64'(acc));

    // Reset in the middle of a pointer move.
    @(negedge Clk);
    bus.ApRequest = 1'b1;
    bus.Dec       = 1'b0;
    @(posedge Clk);
    #1;
    bus.ApRequest = 1'b0;
    do_reset();
    do_req(1'b0, 1'b1, 1'b1);
    do_req(1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
